// File: rtl/bit_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer_pkg
// Description : Shared state encoding and default word length for the
//               bit_serializer block.
// Revision    : 1.0 - initial release
// ============================================================================
package bit_serializer_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    // PARITY is only reachable when BIT_SERIALIZER_PARITY_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage : bit_serializer_pkg
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-to-serial converter, MSB first, valid/ready input,
//               back-to-back frames. Optional even-parity trailer bit when
//               BIT_SERIALIZER_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int              c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic [c_CW-1:0]  r_cnt;
    logic             w_cnt_zero;
    logic             w_frame_end;
    logic             w_xfer;

`ifdef BIT_SERIALIZER_PARITY_EN
    logic             r_parity;
`endif

    assign w_cnt_zero = (r_cnt == '0);
    assign w_xfer     = in_valid && in_ready;

    // Final bit of the frame: opens the in_ready window for back-to-back.
    always_comb begin
        w_frame_end = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        w_frame_end = (r_state == PARITY);
`else
        w_frame_end = (r_state == SHIFT) && w_cnt_zero;
`endif
    end

    // in_ready is gated by reset so it reads 0 for the whole reset interval.
    assign in_ready = reset && ((r_state == IDLE) || w_frame_end);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_cnt_zero) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    w_next_state = PARITY;
`else
                    w_next_state = w_xfer ? SHIFT : IDLE;
`endif
                end
            end
            PARITY: begin
`ifdef BIT_SERIALIZER_PARITY_EN
                w_next_state = w_xfer ? SHIFT : IDLE;
`else
                w_next_state = IDLE;
`endif
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_xfer) begin
            r_shift <= in_data;
            r_cnt   <= c_CNT_LOAD;
        end else if (r_state == SHIFT) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            if (!w_cnt_zero) begin
                r_cnt <= r_cnt - c_CW'(1);
            end
        end
    end

`ifdef BIT_SERIALIZER_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_xfer) begin
            r_parity <= ^in_data;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        ser_bit   = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            SHIFT: begin
                ser_bit   = r_shift[WIDTH-1];
                ser_valid = 1'b1;
                busy      = 1'b1;
            end
            PARITY: begin
`ifdef BIT_SERIALIZER_PARITY_EN
                ser_bit   = r_parity;
`endif
                ser_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                ser_bit   = 1'b0;
                ser_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    assign ser_last = w_frame_end;

endmodule : bit_serializer
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_serializer
// Description : Directed self-checking bench for bit_serializer (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ser_bit;
    logic       ser_valid;
    logic       ser_last;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    bit_serializer #(.WIDTH(8)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ser_bit  (ser_bit),
        .ser_valid(ser_valid),
        .ser_last (ser_last),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, ser_valid, 1'b0);
        check({tag, "_busy"},  busy,      1'b0);
        check({tag, "_bit"},   ser_bit,   1'b0);
        check({tag, "_ready"}, in_ready,  1'b1);
    endtask

    // Two 8-bit frames, the second offered on ser_last of the first.
    // With hold_valid, in_valid stays 1 and in_data churns mid-frame.
    task automatic two_frames(input logic [7:0] w1, input logic [7:0] w2,
                              input logic hold_valid, input string tag);
        logic [15:0] stream;
        int          nv;
        stream = '0;
        nv     = 0;
        in_data  = w1;
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            stream = {stream[14:0], ser_bit};
            nv += int'(ser_valid);
            check($sformatf("%s_last%0d", tag, i), ser_last, (i == 7 || i == 15));
            if (i == 7) begin
                in_data  = w2;
                in_valid = 1'b1;
            end else if (i == 15) begin
                in_valid = 1'b0;
            end else begin
                in_data  = (i % 2 == 1) ? 8'hFF : 8'h5A;
                in_valid = hold_valid;
            end
            step();
        end
        check({tag, "_stream"}, stream, {w1, w2});
        check({tag, "_nvalid"}, nv, 16);
        check_idle({tag, "_after"});
    endtask

    initial begin
        logic [7:0] exp_word;
        logic [8:0] stream9;
        int         nv;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) step();
        check("rst_ready", in_ready,  1'b0);
        check("rst_valid", ser_valid, 1'b0);
        check("rst_last",  ser_last,  1'b0);
        check("rst_busy",  busy,      1'b0);
        check("rst_bit",   ser_bit,   1'b0);
        #3 reset = 1'b1;
        #1;
        check("rel_ready", in_ready,  1'b1);
        check("rel_valid", ser_valid, 1'b0);
        step();

`ifndef BIT_SERIALIZER_PARITY_EN
        // Single frame 8'hA5, cycle-by-cycle.
        exp_word = 8'hA5;
        in_data  = exp_word;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a5_bit%0d",   i), ser_bit,   exp_word[7-i]);
            check($sformatf("a5_valid%0d", i), ser_valid, 1'b1);
            check($sformatf("a5_busy%0d",  i), busy,      1'b1);
            check($sformatf("a5_last%0d",  i), ser_last,  (i == 7));
            check($sformatf("a5_ready%0d", i), in_ready,  (i == 7));
            step();
        end
        check_idle("a5_end");

        two_frames(8'h0A, 8'hA0, 1'b0, "b2b");
        two_frames(8'h3C, 8'h81, 1'b1, "hold");

        // Reset three bits into a frame of 8'hFF.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ff_bit%0d", i), ser_bit, 1'b1);
            if (i < 2) step();
        end
        #2 reset = 1'b0;
        #1;
        check("mid_rst_bit",   ser_bit,   1'b0);
        check("mid_rst_valid", ser_valid, 1'b0);
        check("mid_rst_last",  ser_last,  1'b0);
        check("mid_rst_busy",  busy,      1'b0);
        check("mid_rst_ready", in_ready,  1'b0);
        step();
        check("mid_rst_hold", ser_valid, 1'b0);
        #3 reset = 1'b1;
        #1;
        check("mid_rel_ready", in_ready,  1'b1);
        check("mid_rel_valid", ser_valid, 1'b0);
        in_data  = 8'h01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        exp_word = '0;
        nv       = 0;
        for (int i = 0; i < 8; i++) begin
            exp_word = {exp_word[6:0], ser_bit};
            nv += int'(ser_valid);
            step();
        end
        check("resume_stream", exp_word, 8'h01);
        check("resume_nvalid", nv, 8);
        check_idle("resume_end");
`else
        // Parity build: 8'h07 -> 00000111 then parity 1.
        in_data  = 8'h07;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        stream9  = '0;
        nv       = 0;
        for (int i = 0; i < 9; i++) begin
            stream9 = {stream9[7:0], ser_bit};
            nv += int'(ser_valid);
            check($sformatf("par_last%0d",  i), ser_last, (i == 8));
            check($sformatf("par_ready%0d", i), in_ready, (i == 8));
            step();
        end
        check("par_stream", stream9, 9'b000001111);
        check("par_nvalid", nv, 9);
        check_idle("par_end");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bit_serializer
`default_nettype wire

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 Port: clk  input  1  system clock; all state changes occur on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; asserting it (0) forces the reset state immediately, independent of clk.
REQ-004 Port: in_data  input  WIDTH  parallel word to serialize.
REQ-005 Port: in_valid  input  1  in_data is valid.
REQ-006 Port: in_ready  output  1  block can accept a word this cycle.
REQ-007 Port: ser_bit  output  1  serial bit stream to the downstream sequence detector.
REQ-008 Port: ser_valid  output  1  ser_bit carries a real bit this cycle.
REQ-009 Port: ser_last  output  1  ser_bit is the final bit of the current frame.
REQ-010 Port: busy  output  1  a frame is in progress.

Function
REQ-011 Handshake SHALL be: a word transfers on a clock edge where in_valid=1 and in_ready=1; in_data is ignored at all other times.
REQ-012 States SHALL be IDLE, SHIFT and PARITY (PARITY exists only per REQ-025).
REQ-013 in_ready SHALL be 1 in IDLE, and in SHIFT/PARITY only during the final bit of the frame (ser_last=1); otherwise 0.
REQ-014 Latency: the first bit (MSB, in_data[WIDTH-1]) SHALL appear on ser_bit with ser_valid=1 in the cycle after the transfer.
REQ-015 Bits SHALL be emitted MSB-first, one per cycle, with no gaps, for WIDTH cycles, driven from a shift register captured at transfer.
REQ-016 The down-counter SHALL load WIDTH-1 at transfer and decrement each SHIFT cycle; ser_last=1 when it reaches 0 (and no parity stage follows).
REQ-017 Transfer during the final bit SHALL start the next frame in the following cycle (back-to-back, no idle bubble); otherwise the FSM returns to IDLE.
REQ-018 In IDLE, ser_bit SHALL be 0 and ser_valid, ser_last and busy SHALL be 0.
REQ-019 busy SHALL equal 1 in SHIFT and PARITY.
REQ-020 Changes on in_data or in_valid while in_ready=0 SHALL not affect the frame in progress.

Reset
REQ-021 While reset=0: state=IDLE, shift register=0, counter=0, ser_bit=0, ser_valid=0, ser_last=0, busy=0, in_ready=0.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame immediately; no remaining bits are emitted after release.
REQ-023 After release, in_ready SHALL be 1 from the first cycle, and the first transfer SHALL start a fresh frame.

Configuration
REQ-024 Without BIT_SERIALIZER_PARITY_EN: frames are exactly WIDTH bits, and the PARITY state is absent.
REQ-025 With BIT_SERIALIZER_PARITY_EN: after the WIDTH data bits, a PARITY cycle emits the even-parity bit (XOR of the word), giving WIDTH+1-bit frames; ser_last and the in_ready window move to the parity cycle.

Structure
REQ-026 A shared package bit_serializer_pkg SHALL hold the state enumeration (IDLE, SHIFT, PARITY) and the default WIDTH constant.
REQ-027 The block SHALL be a single module; no sub-module is instantiated.

Verification
REQ-028 Assert reset=0 mid-run -> all outputs read 0 immediately; after release, in_ready=1 and ser_valid=0.
REQ-029 Single transfer of 8'hA5 -> ser_bit 1,0,1,0,0,1,0,1 on cycles 1..8, ser_valid=1 throughout, ser_last=1 on cycle 8 only, in_ready=0 on cycles 1..7.
REQ-030 Back-to-back transfers of 8'h0A then 8'hA0 (second offered on ser_last) -> 16 contiguous valid bits 0000101010100000, with no ser_valid gap.
REQ-031 Transfer 8'hFF, then reset=0 after 3 bits, release, then transfer 8'h01 -> no further 1s from the first word; the stream resumes with 0000000 1.
REQ-032 With BIT_SERIALIZER_PARITY_EN, transfer 8'h07 -> 00000111, then parity bit 1 on cycle 9 with ser_last=1; the frame is 9 cycles.
REQ-033 in_valid held 1 with in_data toggling each cycle during a frame -> only the words present on handshake edges are serialized.
